// File: rtl/hpdcache_mem_wr_responder.sv
// HPDcache memory-side write responder: metadata FIFO, beat commit, ordered responses.
// Optional wlast_i consistency check: define HPDCACHE_MEM_WR_RESP_LAST_CHECK_EN.
module hpdcache_mem_wr_responder #(
   parameter int unsigned AddrWidth     = 49,
   parameter int unsigned DataWidth     = 128,
   parameter int unsigned IdWidth       = 8,
   parameter int unsigned MetaFifoDepth = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic [AddrWidth-1:0]   req_addr_i,
   input  logic [7:0]             req_len_i,
   input  logic [IdWidth-1:0]     req_id_i,
   input  logic [1:0]             req_command_i,
   input  logic                   wdata_valid_i,
   output logic                   wdata_ready_o,
   input  logic [DataWidth-1:0]   wdata_i,
   input  logic [DataWidth/8-1:0] wbe_i,
   input  logic                   wlast_i,
   output logic                   resp_valid_o,
   input  logic                   resp_ready_i,
   output logic [IdWidth-1:0]     resp_id_o,
   output logic                   resp_error_o,
   output logic                   mem_we_o,
   output logic [AddrWidth-1:0]   mem_addr_o,
   output logic [DataWidth-1:0]   mem_wdata_o,
   output logic [DataWidth/8-1:0] mem_be_o,
   output logic                   busy_o
);

   localparam int unsigned OffW = $clog2(DataWidth / 8);
   localparam int unsigned PtrW = $clog2(MetaFifoDepth);
   localparam int unsigned CntW = $clog2(MetaFifoDepth + 1);

   typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;

   state_e state_q, state_d;

   logic [AddrWidth-1:0] f_addr [MetaFifoDepth];
   logic [7:0]           f_len  [MetaFifoDepth];
   logic [IdWidth-1:0]   f_id   [MetaFifoDepth];
   logic [1:0]           f_cmd  [MetaFifoDepth];
   logic [PtrW-1:0]      wptr_q, rptr_q;
   logic [CntW-1:0]      fcnt_q;
   logic                 full, empty, push, pop;

   logic [AddrWidth-1:0] addr_q;
   logic [7:0]           len_q, beat_q;
   logic [IdWidth-1:0]   id_q;
   logic                 err_cmd_q, err_q;
   logic                 beat, last_err;

   assign full        = (fcnt_q == CntW'(MetaFifoDepth));
   assign empty       = (fcnt_q == '0);
   assign req_ready_o = ~full;
   assign push        = req_valid_i & ~full;

   // FIFO storage; contents are only meaningful while counted as occupied
   always_ff @(posedge clk_i) begin
      if (push) begin
         f_addr[wptr_q] <= req_addr_i;
         f_len[wptr_q]  <= req_len_i;
         f_id[wptr_q]   <= req_id_i;
         f_cmd[wptr_q]  <= req_command_i;
      end
   end

   // FIFO pointers and occupancy, wrapping at the configured depth
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         fcnt_q <= '0;
      end else begin
         if (push) begin
            wptr_q <= (wptr_q == PtrW'(MetaFifoDepth - 1)) ? '0 : wptr_q + 1'b1;
         end
         if (pop) begin
            rptr_q <= (rptr_q == PtrW'(MetaFifoDepth - 1)) ? '0 : rptr_q + 1'b1;
         end
         if (push && !pop) begin
            fcnt_q <= fcnt_q + 1'b1;
         end else if (!push && pop) begin
            fcnt_q <= fcnt_q - 1'b1;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state and handshake outputs
   always_comb begin
      state_d       = state_q;
      pop           = 1'b0;
      beat          = 1'b0;
      wdata_ready_o = 1'b0;
      resp_valid_o  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = DATA;
            end
         end
         DATA: begin
            wdata_ready_o = 1'b1;
            if (wdata_valid_i) begin
               beat = 1'b1;
               if (beat_q == len_q) begin
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            resp_valid_o = 1'b1;
            if (resp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef HPDCACHE_MEM_WR_RESP_LAST_CHECK_EN
   assign last_err = beat & (wlast_i != (beat_q == len_q));
`else
   logic unused_wlast;
   assign unused_wlast = wlast_i;
   assign last_err     = 1'b0;
`endif

   // Active transaction registers: loaded on pop, beat counter advances per beat
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q    <= '0;
         len_q     <= '0;
         id_q      <= '0;
         beat_q    <= '0;
         err_cmd_q <= 1'b0;
         err_q     <= 1'b0;
      end else if (pop) begin
         addr_q    <= f_addr[rptr_q];
         len_q     <= f_len[rptr_q];
         id_q      <= f_id[rptr_q];
         beat_q    <= '0;
         err_cmd_q <= (f_cmd[rptr_q] != 2'b00);
         err_q     <= (f_cmd[rptr_q] != 2'b00);
      end else if (beat) begin
         beat_q <= beat_q + 8'd1;
         if (last_err) begin
            err_q <= 1'b1;
         end
      end
   end

   // Write port is zeroed whenever no write is being issued
   assign mem_we_o     = beat & ~err_cmd_q;
   assign mem_addr_o   = mem_we_o ? addr_q + (AddrWidth'(beat_q) << OffW) : '0;
   assign mem_wdata_o  = mem_we_o ? wdata_i : '0;
   assign mem_be_o     = mem_we_o ? wbe_i : '0;
   assign resp_id_o    = resp_valid_o ? id_q : '0;
   assign resp_error_o = resp_valid_o & err_q;
   assign busy_o       = (state_q != IDLE) | ~empty;

endmodule
